// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default constants for the fetch sequencer and its helpers.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_IRQ   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int          INSTR_W          = 16;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'h0010;
  localparam int          DEF_WAIT_LIMIT   = 15;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus: request/address out, acknowledge/data back.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic               mem_req;
  logic [WIDTH-1:0]   mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);

endinterface

// File: rtl/fetch_sequencer_timeout.sv
// Counts unacknowledged fetch cycles; expire fires on the last allowed cycle
// when no ack arrives, so an ack on that same cycle still wins.
module fetch_timeout #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expire = active && !ack && (count == CW'(LIMIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!active || ack || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: sequences FETCH/EXEC per instruction, applies branch
// redirects, vectors interrupts and implements run/halt/single-step control.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(DEF_IRQ_VECTOR),
  parameter int               WAIT_LIMIT   = DEF_WAIT_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               irq,
  input  logic               irq_enable,
  input  logic               branch_valid,
  input  logic [WIDTH-1:0]   branch_target,
  fetch_sequencer_if.master  mem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   return_pc,
  output logic               irq_ack,
  output logic               halted,
  output logic               fault
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   pc_nxt, return_pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic               fault_nxt;
  logic               step_pending, step_pending_nxt;
  logic               mem_req_c;
  logic               expire;

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = pc;

  fetch_timeout #(
    .LIMIT (WAIT_LIMIT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .active (state == ST_FETCH),
    .ack    (mem.mem_ack),
    .expire (expire)
  );

  // Control outputs decode from state so reset removes mem_req without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      pc           <= RESET_VECTOR;
      instr        <= '0;
      return_pc    <= '0;
      fault        <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr        <= instr_nxt;
      return_pc    <= return_pc_nxt;
      fault        <= fault_nxt;
      step_pending <= step_pending_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    instr_nxt        = instr;
    return_pc_nxt    = return_pc;
    fault_nxt        = fault;
    step_pending_nxt = step_pending;
    mem_req_c        = 1'b0;
    instr_valid      = 1'b0;
    irq_ack          = 1'b0;
    halted           = 1'b0;

    unique case (state)
      ST_IDLE: begin
        state_nxt = run ? ST_FETCH : ST_HALT;
      end
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ack) begin
          instr_nxt = mem.mem_data;
          state_nxt = ST_EXEC;
        end else if (expire) begin
          fault_nxt = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        pc_nxt      = branch_valid ? branch_target : pc + WIDTH'(1);
        // Interrupt outranks a pending single-step; the step completes after the handler's first instruction.
        if (irq && irq_enable) begin
          state_nxt = ST_IRQ;
        end else if (step_pending) begin
          step_pending_nxt = 1'b0;
          state_nxt        = ST_HALT;
        end else if (!run) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_IRQ: begin
        irq_ack       = 1'b1;
        return_pc_nxt = pc;
        pc_nxt        = IRQ_VECTOR;
        state_nxt     = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!fault) begin
          if (step) begin
            step_pending_nxt = 1'b1;
            state_nxt        = ST_FETCH;
          end else if (run) begin
            state_nxt = ST_FETCH;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: stimulus pushes expected EXEC/IRQ events, a negedge monitor pops and compares.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, step = 1'b0, irq = 1'b0, irq_enable = 1'b0;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        ack_en = 1'b0;
  logic [15:0] instr, pc, return_pc;
  logic        instr_valid, irq_ack, halted, fault;

  fetch_sequencer_if #(.WIDTH(16)) mif ();

  function automatic logic [15:0] img(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  assign mif.mem_ack  = ack_en;
  assign mif.mem_data = img(mif.mem_addr);

  fetch_sequencer #(
    .WIDTH        (16),
    .RESET_VECTOR (16'h0000),
    .IRQ_VECTOR   (16'h0010),
    .WAIT_LIMIT   (15)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .step          (step),
    .irq           (irq),
    .irq_enable    (irq_enable),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem           (mif),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .return_pc     (return_pc),
    .irq_ack       (irq_ack),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] irq_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_exec = 0;
  bit          irq_chk = 1'b0;
  logic [15:0] irq_exp = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [15:0] a, input int gap);
    exp_t e;
    e.addr = a;
    e.data = img(a);
    e.gap  = gap;
    exp_q.push_back(e);
  endfunction

  // Monitor: every instr_valid / irq_ack pulse consumes one expected entry.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (irq_chk) begin
      check("irq_return_pc", return_pc, irq_exp);
      check("irq_vector_pc", pc, 16'h0010);
      irq_chk = 1'b0;
    end
    if (irq_ack) begin
      if (irq_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_irq_ack: got pulse expected none at pc %0h", pc);
      end else begin
        irq_exp = irq_q.pop_front();
        irq_chk = 1'b1;
      end
    end
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_exec: got pc %0h expected no instr_valid", pc);
      end else begin
        e = exp_q.pop_front();
        check("exec_pc", pc, e.addr);
        check("exec_instr", instr, e.data);
        if (e.gap != 0) check("exec_gap", cyc - last_exec, e.gap);
      end
      last_exec = cyc;
    end
  end

  task automatic wait_exec_at(input logic [15:0] a);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      #1;
      if (instr_valid && pc == a) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_exec: got no EXEC expected EXEC at pc %0h within 60 cycles", a);
  endtask

  task automatic branch_at(input logic [15:0] a, input logic [15:0] tgt, input bit with_irq);
    wait_exec_at(a);
    branch_valid  = 1'b1;
    branch_target = tgt;
    if (with_irq) begin
      irq        = 1'b1;
      irq_enable = 1'b1;
    end
    @(posedge clock);
    #1;
    branch_valid = 1'b0;
    irq          = 1'b0;
  endtask

  task automatic stop_at(input logic [15:0] a);
    wait_exec_at(a);
    run = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mif.mem_req) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_req: got mem_req=0 expected mem_req=1 within 20 cycles");
  endtask

  initial begin
    int req_cnt;
    int act_cnt;
    logic [15:0] first_addr;

    // Reset state
    #1 reset = 1'b0;
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_mem_req", mif.mem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_return_pc", return_pc, 16'h0000);
    check("rst_instr", instr, 16'h0000);

    // Free run with zero-wait memory
    run    = 1'b1;
    ack_en = 1'b1;
    push(16'h0000, 0);
    push(16'h0001, 2);
    push(16'h0002, 2);
    push(16'h0003, 2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("first_fetch_req", mif.mem_req, 1'b1);
    check("first_fetch_addr", mif.mem_addr, 16'h0000);
    check("run_halted", halted, 1'b0);
    stop_at(16'h0003);
    check("stop_halted", halted, 1'b1);
    check("stop_pc", pc, 16'h0004);

    // Single step while halted
    push(16'h0004, 0);
    step = 1'b1;
    @(posedge clock);
    #1 step = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    check("step_halted", halted, 1'b1);
    check("step_pc", pc, 16'h0005);

    // Taken branch, then wrap at 0xFFFF
    push(16'h0005, 0);
    push(16'h0200, 2);
    run = 1'b1;
    branch_at(16'h0005, 16'h0200, 1'b0);
    stop_at(16'h0200);
    push(16'h0201, 0);
    push(16'hFFFF, 2);
    push(16'h0000, 2);
    run = 1'b1;
    branch_at(16'h0201, 16'hFFFF, 1'b0);
    stop_at(16'h0000);
    check("wrap_pc", pc, 16'h0001);

    // Branch and interrupt in the same EXEC
    push(16'h0001, 0);
    push(16'h0040, 2);
    push(16'h0010, 3);
    irq_q.push_back(16'h0100);
    run = 1'b1;
    branch_at(16'h0001, 16'h0040, 1'b0);
    branch_at(16'h0040, 16'h0100, 1'b1);
    stop_at(16'h0010);
    check("irq_after_pc", pc, 16'h0011);
    irq_enable = 1'b0;

    // Fetch timeout
    ack_en     = 1'b0;
    run        = 1'b1;
    req_cnt    = 0;
    first_addr = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (fault) break;
      if (mif.mem_req) begin
        req_cnt++;
        if (req_cnt == 1) first_addr = mif.mem_addr;
      end
    end
    check("timeout_addr", first_addr, 16'h0011);
    check("timeout_req_cycles", req_cnt, 15);
    check("timeout_fault", fault, 1'b1);
    check("timeout_halted", halted, 1'b1);
    step    = 1'b1;
    act_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      if (mif.mem_req || instr_valid) act_cnt++;
    end
    step = 1'b0;
    check("fault_ignores_run_step", act_cnt, 0);
    check("fault_sticky", fault, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_clears_fault", fault, 1'b0);
    check("reset_clears_halted", halted, 1'b0);
    check("reset_pc", pc, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // Ack on the last allowed cycle is accepted
    wait_req();
    repeat (14) @(negedge clock);
    #1;
    check("limit_cycle_req", mif.mem_req, 1'b1);
    check("limit_cycle_fault", fault, 1'b0);
    push(16'h0000, 0);
    ack_en = 1'b1;
    run    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("limit_ack_fault", fault, 1'b0);
    check("limit_ack_halted", halted, 1'b1);
    check("limit_ack_pc", pc, 16'h0001);

    // Reset mid-fetch drops mem_req without a clock edge
    ack_en = 1'b0;
    run    = 1'b1;
    wait_req();
    check("midfetch_addr", mif.mem_addr, 16'h0001);
    #2 reset = 1'b0;
    #1;
    check("async_mem_req", mif.mem_req, 1'b0);
    check("async_pc", pc, 16'h0000);
    push(16'h0000, 0);
    push(16'h0001, 2);
    ack_en = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    stop_at(16'h0001);

    repeat (3) @(negedge clock);
    #1;
    check("exec_q_left", exp_q.size(), 0);
    check("irq_q_left", irq_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
